alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Initiator side of the 8-bit ALU: accepts operation requests, drives the ALU operand/opcode/enable
//  inputs, samples its result and status flags, and returns a registered response. Also chains
//  up to three 8-bit passes to execute 16-bit ADD/SUB/INC/DEC. Sits between instruction decode
//  and the ALU; owns the architectural F (flag) register.
// PARAMETERS
//  (none) -- datapath fixed: 8-bit ALU, 16-bit request/response operands.
// PORTS
//  clk          in   1      system clock, all state on rising edge
//  reset        in   1      asynchronous, active-high reset
//  req_valid    in   1      request present
//  req_ready    out  1      sequencer can accept (high only in IDLE)
//  req_op       in   alu_op operation (ADD, SUB, COMPARE, AND, OR, XOR, shifts, rotates, INC, DEC)
//  req_wide     in   1      1 = 16-bit operation
//  req_a        in   16     operand A (narrow ops use [7:0])
//  req_b        in   16     operand B (narrow ops use [7:0])
//  alu_a        out  8      to ALU a
//  alu_b        out  8      to ALU b
//  alu_opcode   out  alu_op to ALU opcode
//  alu_enable   out  1      to ALU enable
//  alu_out      in   8      from ALU out
//  alu_status   in   8      from ALU status_flag {S,Z,0,H,0,PV,N,C}
//  rsp_valid    out  1      response present
//  rsp_ready    in   1      consumer accepts response
//  rsp_result   out  16     result (narrow: {8'h00,result})
//  rsp_flags    out  8      flags of this operation, same bit layout as alu_status
//  rsp_err      out  1      unsupported request (wide op other than ADD/SUB/INC/DEC)
//  flags_q      out  8      F register; loads rsp_flags on response handshake when rsp_err=0
// BEHAVIOUR
//  Reset (async): state=IDLE; req_ready=1; rsp_valid=0; rsp_err=0; rsp_result=0; rsp_flags=0;
//   flags_q=0; alu_enable=0; alu_a=alu_b=0; alu_opcode=ADD. Reset mid-operation abandons the
//   operation; no response is issued.
//  States: IDLE, LO, HI, FIX, DONE.
//  IDLE: req_valid&req_ready registers op/wide/a/b. Next state LO, or DONE with rsp_err=1 and
//   rsp_result=0 if unsupported.
//  LO: alu_enable=1; drives a[7:0], b[7:0], op; wide INC/DEC drive ADD/SUB with b=1. Samples
//   alu_out/alu_status at end of cycle. Narrow -> DONE; wide -> HI, low carry saved.
//  HI: drives a[15:8], b[15:8] with ADD/SUB -> FIX if saved low C=1, else DONE.
//  FIX: drives INC (ADD) or DEC (SUB) on HI result -> DONE.
//  DONE: rsp_valid=1; outputs stable until rsp_valid&rsp_ready -> IDLE (req_ready=1 next cycle).
//  alu_enable=0 and ALU inputs at reset values in IDLE and DONE.
//  Latency from accept edge to rsp_valid: narrow 2 cycles; wide 3, or 4 with FIX.
//   Throughput: one request in flight.
//  Narrow flags: alu_status verbatim. COMPARE: rsp_result={8'h00,a[7:0]}; flags from the ALU.
//  Wide flags:
//   - S=result[15]; Z=(result==16'h0); H from HI pass.
//   - PV=16-bit signed overflow from a[15], b'[15], result[15]; b'=1 for INC/DEC.
//   - N=1 for SUB/DEC, else 0. C=C_hi|C_fix (mutually exclusive).
//   - Bits 5 and 3 are always 0.
//  req_* ignored outside IDLE. rsp_err response leaves flags_q unchanged.
// TESTING
//  1 narrow ADD a=0x7F b=0x01 -> rsp_valid 2 cycles after accept; result 0x0080;
//    flags S=1 Z=0 H=1 PV=1 N=0 C=0.
//  2 wide ADD a=0x00FF b=0x0001 -> LO,HI,FIX visited; rsp_valid at +4; result 0x0100;
//    C=0 Z=0 S=0.
//  3 wide SUB a=0x0000 b=0x0001 -> result 0xFFFF; S=1 N=1 C=1 Z=0; FIX (DEC) pass observed.
//  4 narrow COMPARE a=0x10 b=0x10 -> result 0x0010; Z=1 N=1 C=0;
//    flags_q=rsp_flags after handshake.
//  5 rsp_ready held 0 for 5 cycles in DONE -> rsp_* stable; req_ready=0; alu_enable=0;
//    new req_valid ignored.
//  6 wide AND -> rsp_err=1, result 0, flags_q unchanged;
//    reset asserted in HI -> rsp_valid=0, alu_enable=0, flags_q=0 immediately.

Source files
------------

// File: rtl/alu_sequencer.sv
// Initiator for an external 8-bit ALU: runs one narrow pass or chains LO/HI/FIX passes
// for 16-bit ADD/SUB/INC/DEC, returns a registered response and owns the F register.
package alu_sequencer_pkg;
  typedef enum logic [3:0] {
    ALU_ADD = 4'd0,
    ALU_SUB = 4'd1,
    ALU_CMP = 4'd2,
    ALU_AND = 4'd3,
    ALU_OR  = 4'd4,
    ALU_XOR = 4'd5,
    ALU_SLA = 4'd6,
    ALU_SRA = 4'd7,
    ALU_SRL = 4'd8,
    ALU_RLC = 4'd9,
    ALU_RRC = 4'd10,
    ALU_INC = 4'd11,
    ALU_DEC = 4'd12
  } alu_op;
endpackage

module alu_sequencer
  import alu_sequencer_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  alu_op       req_op,
  input  logic        req_wide,
  input  logic [15:0] req_a,
  input  logic [15:0] req_b,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output alu_op       alu_opcode,
  output logic        alu_enable,
  input  logic [7:0]  alu_out,
  input  logic [7:0]  alu_status,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [15:0] rsp_result,
  output logic [7:0]  rsp_flags,
  output logic        rsp_err,
  output logic [7:0]  flags_q
);

  typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} state_t;

  state_t      state;
  alu_op       op_q;
  logic        wide_q;
  logic [15:0] a_q;
  logic [7:0]  b_hi_q;
  logic [7:0]  lo_q;
  logic        lo_c;
  logic        hi_c;
  logic        hi_h;

  logic        wide_sub;
  logic        wide_step;
  logic [7:0]  b_hi;
  logic [15:0] wide_res;
  logic        wide_pv;
  logic        fix_c;

  function automatic logic wide_ok(input alu_op op);
    return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_INC) || (op == ALU_DEC);
  endfunction

  function automatic alu_op base_op(input alu_op op);
    if (op == ALU_INC) return ALU_ADD;
    if (op == ALU_DEC) return ALU_SUB;
    return op;
  endfunction

  function automatic logic [7:0] pack_flags(input logic [15:0] res, input logic h,
                                            input logic pv, input logic n, input logic c);
    return {res[15], (res == 16'h0000), 1'b0, h, 1'b0, pv, n, c};
  endfunction

  // Wide INC/DEC behave as ADD/SUB with a 16-bit operand of 1, so the high byte of b is 0.
  assign wide_sub  = (op_q == ALU_SUB) || (op_q == ALU_DEC);
  assign wide_step = (op_q == ALU_INC) || (op_q == ALU_DEC);
  assign b_hi      = wide_step ? 8'h00 : b_hi_q;
  assign wide_res  = {alu_out, lo_q};
  assign wide_pv   = wide_sub ? ((a_q[15] != b_hi[7]) && (wide_res[15] != a_q[15]))
                              : ((a_q[15] == b_hi[7]) && (wide_res[15] != a_q[15]));
  // The FIX pass carries out only when INC wraps to 00 or DEC wraps to FF.
  assign fix_c     = wide_sub ? (alu_out == 8'hFF) : (alu_out == 8'h00);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      req_ready  <= 1'b1;
      rsp_valid  <= 1'b0;
      rsp_err    <= 1'b0;
      rsp_result <= 16'h0000;
      rsp_flags  <= 8'h00;
      flags_q    <= 8'h00;
      alu_enable <= 1'b0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_opcode <= ALU_ADD;
      op_q       <= ALU_ADD;
      wide_q     <= 1'b0;
      a_q        <= 16'h0000;
      b_hi_q     <= 8'h00;
      lo_q       <= 8'h00;
      lo_c       <= 1'b0;
      hi_c       <= 1'b0;
      hi_h       <= 1'b0;
    end else begin
      // Every state lasts one cycle except IDLE/DONE, so the ALU drive defaults to idle
      // and is re-armed only on the edge that enters LO, HI or FIX.
      alu_enable <= 1'b0;
      alu_a      <= 8'h00;
      alu_b      <= 8'h00;
      alu_opcode <= ALU_ADD;
      case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            op_q      <= req_op;
            wide_q    <= req_wide;
            a_q       <= req_a;
            b_hi_q    <= req_b[15:8];
            req_ready <= 1'b0;
            if (req_wide && !wide_ok(req_op)) begin
              rsp_err    <= 1'b1;
              rsp_result <= 16'h0000;
              rsp_flags  <= 8'h00;
              rsp_valid  <= 1'b1;
              state      <= DONE;
            end else begin
              rsp_err    <= 1'b0;
              alu_enable <= 1'b1;
              alu_a      <= req_a[7:0];
              alu_b      <= (req_wide && (req_op == ALU_INC || req_op == ALU_DEC))
                            ? 8'h01 : req_b[7:0];
              alu_opcode <= req_wide ? base_op(req_op) : req_op;
              state      <= LO;
            end
          end
        end
        LO: begin
          if (wide_q) begin
            lo_q       <= alu_out;
            lo_c       <= alu_status[0];
            alu_enable <= 1'b1;
            alu_a      <= a_q[15:8];
            alu_b      <= b_hi;
            alu_opcode <= base_op(op_q);
            state      <= HI;
          end else begin
            rsp_result <= {8'h00, (op_q == ALU_CMP) ? a_q[7:0] : alu_out};
            rsp_flags  <= alu_status;
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        HI: begin
          hi_c <= alu_status[0];
          hi_h <= alu_status[4];
          if (lo_c) begin
            alu_enable <= 1'b1;
            alu_a      <= alu_out;
            alu_opcode <= wide_sub ? ALU_DEC : ALU_INC;
            state      <= FIX;
          end else begin
            rsp_result <= wide_res;
            rsp_flags  <= pack_flags(wide_res, alu_status[4], wide_pv, wide_sub, alu_status[0]);
            rsp_valid  <= 1'b1;
            state      <= DONE;
          end
        end
        FIX: begin
          rsp_result <= wide_res;
          rsp_flags  <= pack_flags(wide_res, hi_h, wide_pv, wide_sub, hi_c | fix_c);
          rsp_valid  <= 1'b1;
          state      <= DONE;
        end
        DONE: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            req_ready <= 1'b1;
            if (!rsp_err) flags_q <= rsp_flags;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
